// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external 8-bit adder between NUM_REQ requesters.
// Define ADDER_ARB_STATS_EN to add the txn_count response counter output.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ctrl_en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 add_valid_in,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    input  logic                 add_valid_out,
    input  logic [8:0]           add_c,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [8:0]           rsp_c,
    output logic                 idle,
    output logic                 err,
    input  logic                 err_clr
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]          txn_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [ID_W-1:0] r_ptr;
    logic            r_inflight;
    logic [ID_W-1:0] r_inflightId;

    logic [ID_W-1:0] w_candIdx;
    logic [ID_W-1:0] w_grantIdx;
    logic            w_found;
    logic            w_grantEn;
    logic            w_rspFire;
    logic            w_errSet;

    // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
    always_comb begin
        w_candIdx  = '0;
        w_grantIdx = '0;
        w_found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_candIdx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_candIdx]) begin
                w_found    = 1'b1;
                w_grantIdx = w_candIdx;
            end
        end
    end

    assign w_grantEn = (r_state == RUN) && w_found;
    assign w_rspFire = add_valid_out && r_inflight;
    assign w_errSet  = add_valid_out ^ r_inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The single outstanding issue retires in the cycle its result is due, so DRAIN can leave then.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (ctrl_en) w_nextState = RUN;
            RUN:     if (!ctrl_en) w_nextState = DRAIN;
            DRAIN: begin
                if (ctrl_en) begin
                    w_nextState = RUN;
                end else if (!r_inflight || add_valid_out) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        add_valid_in = 1'b0;
        add_a        = 8'h00;
        add_b        = 8'h00;
        if (w_grantEn) begin
            req_ready[w_grantIdx] = 1'b1;
            add_valid_in          = 1'b1;
            add_a                 = req_a[{w_grantIdx, 3'b000} +: 8];
            add_b                 = req_b[{w_grantIdx, 3'b000} +: 8];
        end
        idle = (r_state == IDLE) && !r_inflight;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_inflight   <= 1'b0;
            r_inflightId <= '0;
        end else begin
            r_inflight <= w_grantEn;
            if (w_grantEn) begin
                r_inflightId <= w_grantIdx;
                if (w_grantIdx == ID_W'(NUM_REQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_grantIdx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= 9'h000;
        end else begin
            rsp_valid <= w_rspFire;
            if (w_rspFire) begin
                rsp_id <= r_inflightId;
                rsp_c  <= add_c;
            end
        end
    end

    // A new protocol violation wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (w_errSet) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= 16'h0000;
        end else if (err_clr) begin
            txn_count <= 16'h0000;
        end else if (w_rspFire && (txn_count != 16'hFFFF)) begin
            txn_count <= txn_count + 16'h0001;
        end
    end
`endif

endmodule
